// File: rtl/aoi_pkg.sv
// Shared types and defaults for the pipelined AND-OR-INVERT array.
package aoi_pkg;

  typedef enum logic [1:0] {
    AOI_M = 2'd0,
    AO_M  = 2'd1,
    OAI_M = 2'd2,
    OA_M  = 2'd3
  } aoi_mode_e;

  localparam int CNT_W_DEF = 16;

  // OAI/OA reduce each term with OR first; AOI/AO reduce with AND.
  function automatic logic mode_is_or(input aoi_mode_e m);
    return (m == OAI_M) || (m == OA_M);
  endfunction

endpackage

// File: rtl/aoi_pipe_array_if.sv
// Upstream request / downstream result handshake of aoi_pipe_array.
interface aoi_pipe_array_if
  import aoi_pkg::*;
#(
  parameter int GROUPS = 4,
  parameter int TERM_W = 2
);

  logic [GROUPS*TERM_W-1:0] in_data;
  aoi_mode_e                in_mode;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_y;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_y, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_y, out_valid
  );

endinterface

// File: rtl/aoi_term_reduce.sv
// Per-term first-level reduction: AND of each term, or OR of each term.
module aoi_term_reduce #(
  parameter int TERM_W = 2,
  parameter int GROUPS = 4
) (
  input  logic [GROUPS*TERM_W-1:0] data_i,
  input  logic                     or_class_i,
  output logic [GROUPS-1:0]        p_o
);

  // Reduce every TERM_W-bit slice to one partial bit.
  always_comb begin
    p_o = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (or_class_i) begin
        p_o[g] = |data_i[g*TERM_W +: TERM_W];
      end else begin
        p_o[g] = &data_i[g*TERM_W +: TERM_W];
      end
    end
  end

endmodule

// File: rtl/aoi_pipe_array.sv
// Two-stage valid/ready AND-OR-INVERT array with per-transaction mode
// and a saturating count of delivered 1 results.
module aoi_pipe_array
  import aoi_pkg::*;
#(
  parameter int GROUPS = 4,
  parameter int TERM_W = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  aoi_pipe_array_if.slave  bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_true
);

  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic              deliver;
  logic [GROUPS-1:0] term_p;

  logic              s1_valid_q, s1_valid_d;
  logic [GROUPS-1:0] s1_p_q,     s1_p_d;
  aoi_mode_e         s1_mode_q,  s1_mode_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_y_q,     s2_y_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  aoi_term_reduce #(
    .TERM_W (TERM_W),
    .GROUPS (GROUPS)
  ) u_reduce (
    .data_i     (bus.in_data),
    .or_class_i (mode_is_or(bus.in_mode)),
    .p_o        (term_p)
  );

  always_comb begin
    s2_adv  = !s2_valid_q || bus.out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    accept  = bus.in_valid && s1_adv;
    deliver = s2_valid_q && bus.out_ready;
  end

  // Data is only captured on accept, so idle-cycle X on in_data never enters the pipe.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_p_d    = term_p;
        s1_mode_d = bus.in_mode;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (s1_mode_q)
          AOI_M:   s2_y_d = ~|s1_p_q;
          AO_M:    s2_y_d =  |s1_p_q;
          OAI_M:   s2_y_d = ~&s1_p_q;
          OA_M:    s2_y_d =  &s1_p_q;
          default: s2_y_d = 1'b0;
        endcase
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (deliver && s2_y_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_mode_q  <= AOI_M;
      s2_valid_q <= 1'b0;
      s2_y_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_y     = s2_y_q;
  assign bus.out_valid = s2_valid_q;
  assign cnt_true      = cnt_q;

endmodule

// File: tb/tb_aoi_pipe_array.sv
// Directed bench for aoi_pipe_array: default, narrow-counter and 1x1 instances.
module tb_aoi_pipe_array;
  import aoi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] cnt_c;
  int total = 0;
  int bad   = 0;

  aoi_pipe_array_if #(.GROUPS(4), .TERM_W(2)) a ();
  aoi_pipe_array_if #(.GROUPS(4), .TERM_W(2)) b ();
  aoi_pipe_array_if #(.GROUPS(1), .TERM_W(1)) c ();

  aoi_pipe_array #(.GROUPS(4), .TERM_W(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(a), .clr_cnt(clr_a), .cnt_true(cnt_a));
  aoi_pipe_array #(.GROUPS(4), .TERM_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b), .clr_cnt(clr_b), .cnt_true(cnt_b));
  aoi_pipe_array #(.GROUPS(1), .TERM_W(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .bus(c), .clr_cnt(clr_c), .cnt_true(cnt_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  aoi_mode_e   sweep_mode [4] = '{AOI_M, AO_M, OAI_M, OA_M};
  logic        sweep_exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0]  bp_data    [6] = '{8'h03, 8'h00, 8'hC0, 8'h30, 8'h55, 8'hFF};
  logic        bp_exp     [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  aoi_mode_e   cr_mode    [5] = '{AOI_M, AO_M, OAI_M, OA_M, AOI_M};
  logic        cr_data    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        cr_exp     [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        exp_q[$];
  int          sent;
  int          got;

  initial begin
    a.in_data = '0; a.in_mode = AOI_M; a.in_valid = 1'b0; a.out_ready = 1'b0;
    b.in_data = '0; b.in_mode = AOI_M; b.in_valid = 1'b0; b.out_ready = 1'b1;
    c.in_data = '0; c.in_mode = AOI_M; c.in_valid = 1'b0; c.out_ready = 1'b1;

    // Reset state
    #100;
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_out_y",     32'(a.out_y),     32'd0);
    chk("rst_cnt",       32'(cnt_a),       32'd0);
    chk("rst_in_ready",  32'(a.in_ready),  32'd1);
    @(negedge clk); rst = 1'b0;

    // Test 1: AOI, 8'h55 -> every AND term is 0 -> y=1 at latency 2
    @(negedge clk);
    a.in_data = 8'h55; a.in_mode = AOI_M; a.in_valid = 1'b1; a.out_ready = 1'b1;
    @(negedge clk); a.in_valid = 1'b0;
    chk("t1_lat1_valid", 32'(a.out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(a.out_valid), 32'd1);
    chk("t1_y",     32'(a.out_y),     32'd1);
    @(negedge clk);
    chk("t1_bubble", 32'(a.out_valid), 32'd0);
    chk("t1_cnt",    32'(cnt_a),       32'd1);
    clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    chk("t1_clr", 32'(cnt_a), 32'd0);

    // Test 2: mode sweep on 8'h03 -> 0,1,1,0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        a.in_data = 8'h03; a.in_mode = sweep_mode[i]; a.in_valid = 1'b1;
      end else begin
        a.in_valid = 1'b0; a.in_mode = OA_M;
      end
      if (i >= 2) begin
        chk("t2_valid", 32'(a.out_valid), 32'd1);
        chk("t2_y",     32'(a.out_y),     32'(sweep_exp[i-2]));
      end
    end
    @(negedge clk);
    chk("t2_idle", 32'(a.out_valid), 32'd0);
    chk("t2_cnt",  32'(cnt_a),       32'd2);

    // Test 3: backpressure, scoreboard in accept order
    sent = 0; got = 0;
    for (int cy = 0; cy < 60 && got < 6; cy++) begin
      @(negedge clk);
      a.out_ready = (cy >= 5);
      a.in_valid  = (sent < 6);
      a.in_data   = bp_data[(sent < 6) ? sent : 0];
      a.in_mode   = AO_M;
      #1;
      if (cy == 2) chk("t3_full_in_ready", 32'(a.in_ready), 32'd0);
      if (cy >= 2 && cy < 5) begin
        chk("t3_hold_valid", 32'(a.out_valid), 32'd1);
        chk("t3_hold_y",     32'(a.out_y),     32'd1);
      end
      if (a.out_valid && a.out_ready) begin
        chk("t3_no_dup", 32'(got < sent), 32'd1);
        if (exp_q.size() > 0) chk("t3_order", 32'(a.out_y), 32'(exp_q.pop_front()));
        got++;
      end
      if (a.in_valid && a.in_ready) begin
        exp_q.push_back(bp_exp[sent]);
        sent++;
      end
    end
    a.in_valid = 1'b0;
    chk("t3_sent", 32'(sent), 32'd6);
    chk("t3_got",  32'(got),  32'd6);
    @(negedge clk);
    chk("t3_cnt", 32'(cnt_a), 32'd6);

    // Test 4: 2-bit counter saturates at 3, clear beats increment
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b.in_data = 8'h03; b.in_mode = AO_M; b.in_valid = 1'b1;
    end
    @(negedge clk); b.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_sat", 32'(cnt_b), 32'd3);
    b.in_valid = 1'b1;
    @(negedge clk); b.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_deliver_valid", 32'(b.out_valid), 32'd1);
    chk("t4_pre_clr",       32'(cnt_b),       32'd3);
    clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    chk("t4_clr_prio", 32'(cnt_b), 32'd0);
    b.in_valid = 1'b1;
    @(negedge clk); b.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_after_clr", 32'(cnt_b), 32'd1);

    // Test 5: async reset with both stages full
    a.out_ready = 1'b0;
    a.in_data = 8'h03; a.in_mode = AO_M; a.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); a.in_valid = 1'b0;
    chk("t5_full_valid", 32'(a.out_valid), 32'd1);
    chk("t5_full_ready", 32'(a.in_ready),  32'd0);
    chk("t5_cnt_before", 32'(cnt_a),       32'd6);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(a.out_valid), 32'd0);
    chk("t5_async_cnt",   32'(cnt_a),       32'd0);
    chk("t5_async_y",     32'(a.out_y),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    a.in_data = 8'h55; a.in_mode = OA_M; a.in_valid = 1'b1; a.out_ready = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0; a.in_data = 'x; a.in_mode = AOI_M;
    chk("t5_lat1", 32'(a.out_valid), 32'd0);
    @(negedge clk);
    chk("t5_valid", 32'(a.out_valid), 32'd1);
    chk("t5_y",     32'(a.out_y),     32'd1);
    @(negedge clk);
    chk("t5_bubble", 32'(a.out_valid), 32'd0);
    chk("t5_x_gate", 32'(a.out_y),     32'd1);
    chk("t5_cnt",    32'(cnt_a),       32'd1);
    a.in_data = '0;

    // Test 6: GROUPS=1, TERM_W=1 corner
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 5) begin
        c.in_data = cr_data[i]; c.in_mode = cr_mode[i]; c.in_valid = 1'b1;
      end else begin
        c.in_valid = 1'b0;
      end
      if (i >= 2) begin
        chk("t6_valid", 32'(c.out_valid), 32'd1);
        chk("t6_y",     32'(c.out_y),     32'(cr_exp[i-2]));
      end
    end
    @(negedge clk);
    chk("t6_cnt", 32'(cnt_c), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
